fifo_rd_burst_drainer: RTL and testbench

- Read-side consumer for async_fifo; sits entirely in the rd_clk domain.
- Drives the FIFO read port (rd_en, rd_data, empty, half_empty), absorbs the FIFO's one-cycle read latency, and presents the words as a ready/valid stream framed into fixed-length bursts with a last marker.
- Holds a 2-entry skid buffer, so a stalled consumer never causes a lost word or a FIFO underflow.

---
 rtl/fifo_rd_burst_drainer_pkg.sv | 13 +
 rtl/fifo_rd_burst_drainer_skid_buf2.sv | 58 +++++
 rtl/fifo_rd_burst_drainer.sv | 88 ++++++++
 tb/tb_fifo_rd_burst_drainer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_burst_drainer_pkg.sv
// Shared types and constants for the read-side FIFO burst drainer.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_burst_drainer_skid_buf2.sv
// Two-entry output buffer carrying {last, data}; the upstream credit rule
// guarantees it is never written while full without a simultaneous pop.
module skid_buf2 import fifo_drain_pkg::*; #(
  parameter int W = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occ
);

  logic [W-1:0] head, tail;
  logic         pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != '0);
  assign out_data  = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case (occ)
        OCC_W'(0): begin
          if (in_valid) begin
            head <= in_data;
            occ  <= OCC_W'(1);
          end
        end
        OCC_W'(1): begin
          if (in_valid && pop) begin
            head <= in_data;
          end else if (in_valid) begin
            tail <= in_data;
            occ  <= OCC_W'(2);
          end else if (pop) begin
            occ  <= OCC_W'(0);
          end
        end
        default: begin
          // Full: the older tail moves up; a concurrent capture refills the tail.
          if (pop) begin
            head <= tail;
            if (in_valid) tail <= in_data;
            else          occ  <= OCC_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_burst_drainer.sv
// Read-domain consumer: pulls fixed-length bursts from an async FIFO and
// presents them as a ready/valid stream with a last marker.
module fifo_rd_burst_drainer import fifo_drain_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int BURST_MODE = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_half_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_out
);

  localparam int             BCW      = $clog2(BURST_LEN + 1);
  localparam logic [BCW-1:0] LEN      = BCW'(BURST_LEN);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(BURST_LEN - 1);

  state_e           state;
  logic [BCW-1:0]   issued, delivered;
  logic             inflight, inflight_last;
  logic [OCC_W-1:0] occ;
  logic             pop, start_ok, credit_ok;

  assign pop      = m_valid && m_ready;
  assign start_ok = (BURST_MODE != 0) ? !fifo_half_empty : !fifo_empty;
  // Words already owed to the skid (held + in flight), less the one leaving now.
  assign credit_ok = ({1'b0, occ} + {{OCC_W{1'b0}}, inflight})
                   < ((OCC_W+1)'(SKID_DEPTH) + {{OCC_W{1'b0}}, pop});
  assign fifo_rd_en = (state == BURST) && !fifo_empty && (issued < LEN) && credit_ok;
  assign busy       = (state != IDLE);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state         <= IDLE;
      issued        <= '0;
      delivered     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      words_out     <= '0;
    end else begin
      inflight      <= fifo_rd_en;
      // Order is preserved, so the issue index is also the delivered index.
      inflight_last <= fifo_rd_en && (issued == LAST_IDX);
      if (pop) words_out <= words_out + CNT_WIDTH'(1);
      case (state)
        IDLE: begin
          if (enable && start_ok) begin
            state     <= BURST;
            issued    <= '0;
            delivered <= '0;
          end
        end
        BURST: begin
          if (fifo_rd_en) issued <= issued + BCW'(1);
          if (pop) delivered <= delivered + BCW'(1);
          if (issued == LEN) state <= FLUSH;
        end
        FLUSH: begin
          if (pop) delivered <= delivered + BCW'(1);
          if (pop && delivered == LAST_IDX) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skid_buf2 #(.W(DATA_WIDTH + 1)) u_skid (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .in_valid  (inflight),
    .in_data   ({inflight_last, fifo_rd_data}),
    .out_valid (m_valid),
    .out_data  ({m_last, m_data}),
    .out_ready (m_ready),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_rd_burst_drainer.sv
// Directed bench: two drainers (start-on-not-empty and start-on-half) fed by
// behavioural FIFOs with one-cycle read latency.
module tb_fifo_rd_burst_drainer;

  logic rd_clk = 1'b0;
  logic rd_rst_n = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  // ---------------- instance A: BURST_MODE=0 ----------------
  logic        a_en, a_rd_en, a_empty, a_half, a_valid, a_last, a_ready, a_busy;
  logic [31:0] a_rd_data = '0, a_data, a_words;
  logic [31:0] mem_a [0:255];
  int          wpa = 0, rpa = 0;

  assign a_empty = (wpa == rpa);
  assign a_half  = (wpa - rpa) < 128;
  always @(posedge rd_clk) if (a_rd_en) begin
    a_rd_data <= mem_a[rpa % 256];
    rpa       <= rpa + 1;
  end

  fifo_rd_burst_drainer #(.DATA_WIDTH(32), .BURST_LEN(4), .BURST_MODE(0), .CNT_WIDTH(32)) dut_a (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(a_en), .fifo_rd_en(a_rd_en),
    .fifo_rd_data(a_rd_data), .fifo_empty(a_empty), .fifo_half_empty(a_half),
    .m_valid(a_valid), .m_data(a_data), .m_last(a_last), .m_ready(a_ready),
    .busy(a_busy), .words_out(a_words)
  );

  // ---------------- instance B: BURST_MODE=1 ----------------
  logic        b_en, b_rd_en, b_empty, b_half, b_valid, b_last, b_ready, b_busy;
  logic [31:0] b_rd_data = '0, b_data, b_words;
  logic [31:0] mem_b [0:255];
  int          wpb = 0, rpb = 0;

  assign b_empty = (wpb == rpb);
  assign b_half  = (wpb - rpb) < 128;
  always @(posedge rd_clk) if (b_rd_en) begin
    b_rd_data <= mem_b[rpb % 256];
    rpb       <= rpb + 1;
  end

  fifo_rd_burst_drainer #(.DATA_WIDTH(32), .BURST_LEN(4), .BURST_MODE(1), .CNT_WIDTH(32)) dut_b (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(b_en), .fifo_rd_en(b_rd_en),
    .fifo_rd_data(b_rd_data), .fifo_empty(b_empty), .fifo_half_empty(b_half),
    .m_valid(b_valid), .m_data(b_data), .m_last(b_last), .m_ready(b_ready),
    .busy(b_busy), .words_out(b_words)
  );

  logic [31:0] expq [$];

  task automatic push_a(input logic [31:0] d);
    mem_a[wpa % 256] = d;
    expq.push_back(d);
    wpa++;
  endtask

  task automatic push_b(input logic [31:0] d);
    mem_b[wpb % 256] = d;
    wpb++;
  endtask

  // Stream scoreboard and protocol monitors for A, sampled mid-cycle.
  bit          sb_on = 0, prev_stall = 0, prev_busy = 0, prev_last = 0;
  logic [31:0] prev_data = '0;
  int          pop_idx = 0, out_cnt = 0, cred_viol = 0, uf_viol = 0, starts = 0, p;

  always @(negedge rd_clk) if (sb_on) begin
    p = (a_valid && a_ready) ? 1 : 0;
    if (prev_stall) begin
      chk("stall_valid", a_valid, 1);
      chk("stall_data", a_data, prev_data);
      chk("stall_last", a_last, prev_last);
    end
    if (p == 1) begin
      chk("sb_avail", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        chk("sb_data", a_data, expq.pop_front());
        chk("sb_last", a_last, (pop_idx % 4) == 3);
      end
      pop_idx++;
    end
    if (a_rd_en && (out_cnt - p) >= 2) cred_viol++;
    if (a_rd_en && a_empty) uf_viol++;
    out_cnt += (a_rd_en ? 1 : 0) - p;
    if (a_busy && !prev_busy) starts++;
    prev_stall = a_valid && !a_ready;
    prev_data  = a_data;
    prev_last  = a_last;
    prev_busy  = a_busy;
  end

  initial begin
    int n;
    a_en = 0; a_ready = 0; b_en = 0; b_ready = 1;
    step(2);
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_rd_en", a_rd_en, 0);
    chk("rst_last", a_last, 0);
    chk("rst_data", a_data, 0);
    chk("rst_words", a_words, 0);
    rd_rst_n = 1;
    step(1);
    sb_on = 1;

    // Happy path: four back-to-back words
    a_en = 1; a_ready = 1;
    for (int i = 0; i < 4; i++) push_a(32'h10 + i);
    n = 0;
    while (!a_valid && n < 20) begin step(1); n++; end
    for (int i = 0; i < 4; i++) begin
      chk("t1_v", a_valid, 1);
      chk("t1_d", a_data, 32'h10 + i);
      chk("t1_l", a_last, i == 3);
      step(1);
    end
    n = 0;
    while (a_busy && n < 20) begin step(1); n++; end
    chk("t1_idle", a_busy, 0);
    chk("t1_words", a_words, 4);

    // Back-pressure: ready pattern 1,0,0,1
    for (int i = 0; i < 4; i++) push_a(32'hA0 + i);
    for (int i = 0; i < 40; i++) begin
      a_ready = (i % 4 == 0) || (i % 4 == 3);
      step(1);
    end
    a_ready = 1;
    chk("t2_words", a_words, 8);
    chk("t2_idle", a_busy, 0);

    // Mid-burst empty: burst waits for the second half
    push_a(32'h1); push_a(32'h2);
    step(20);
    chk("t3_wait_busy", a_busy, 1);
    chk("t3_wait_words", a_words, 10);
    push_a(32'h3); push_a(32'h4);
    n = 0;
    while (a_busy && n < 50) begin step(1); n++; end
    chk("t3_idle", a_busy, 0);
    chk("t3_words", a_words, 12);
    chk("t3_starts", starts, 3);

    // Enable dropped after the 2nd word: burst still completes
    for (int i = 5; i <= 8; i++) push_a(i);
    n = 0;
    while (a_words < 14 && n < 50) begin step(1); n++; end
    a_en = 0;
    n = 0;
    while (a_busy && n < 50) begin step(1); n++; end
    chk("t4_words", a_words, 16);
    chk("t4_starts", starts, 4);
    for (int i = 0; i < 4; i++) push_a(32'h20 + i);
    step(10);
    chk("t4_nostart", a_busy, 0);
    chk("t4_rd_en", a_rd_en, 0);
    chk("t4_starts2", starts, 4);

    // Half-empty start on B
    for (int i = 0; i < 127; i++) push_b(i);
    b_en = 1;
    step(10);
    chk("b_hold_busy", b_busy, 0);
    chk("b_hold_reads", rpb, 0);
    push_b(127); push_b(128);
    n = 0;
    do begin @(negedge rd_clk); n++; end while (!b_rd_en && n < 10);
    chk("b_start_lat", b_rd_en && (n <= 3), 1);
    step(1);
    n = 0;
    while (b_busy && n < 50) begin step(1); n++; end
    chk("b_idle", b_busy, 0);
    chk("b_words", b_words, 4);

    // Reset mid-burst on A with the consumer stalled
    a_ready = 0; a_en = 1;
    step(6);
    chk("t5_busy", a_busy, 1);
    chk("t5_valid", a_valid, 1);
    sb_on = 0;
    chk("uf_viol", uf_viol, 0);
    chk("cred_viol", cred_viol, 0);
    rd_rst_n = 0;
    #1;
    chk("t5_rst_valid", a_valid, 0);
    chk("t5_rst_rd_en", a_rd_en, 0);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_last", a_last, 0);
    chk("t5_rst_data", a_data, 0);
    chk("t5_rst_words", a_words, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
